// File: rtl/comb_truth_scanner_pkg.sv
// rtl/comb_truth_scanner_pkg.sv - shared constants and state encoding for the truth-table scanner
package comb_truth_scanner_pkg;

    localparam int DEF_N_IN   = 3;
    localparam int DEF_SETTLE = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } scan_state_t;

endpackage

// File: rtl/comb_truth_scanner_if.sv
// rtl/comb_truth_scanner_if.sv - control/result bundle between scanner and its host
interface comb_truth_scanner_if #(
    parameter int N_IN = 3
);
    logic                 start;
    logic                 abort;
    logic [2**N_IN-1:0]   expect_in;
    logic                 y_in;
    logic [N_IN-1:0]      cba_out;
    logic                 busy;
    logic                 done;
    logic                 valid;
    logic [2**N_IN-1:0]   table_out;
    logic [N_IN:0]        ones_cnt;
    logic                 pass;

    modport master (
        output start, abort, expect_in, y_in,
        input  cba_out, busy, done, valid, table_out, ones_cnt, pass
    );

    modport slave (
        input  start, abort, expect_in, y_in,
        output cba_out, busy, done, valid, table_out, ones_cnt, pass
    );
endinterface

// File: rtl/comb_truth_scanner_settle_timer.sv
// rtl/comb_truth_scanner_settle_timer.sv - per-code settle counter with clear and terminal count
module scan_settle_timer #(
    parameter int SETTLE = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc
);
    localparam int W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    logic [W-1:0] cnt;

    // tc marks the last settle cycle; the counter parks there until cleared
    assign tc = (cnt == W'(SETTLE - 1));

    // Count settle cycles while enabled, restart on clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && !tc) begin
            cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/comb_truth_scanner.sv
// rtl/comb_truth_scanner.sv - sweeps all input codes of a combinational block and captures its truth table
module comb_truth_scanner
    import comb_truth_scanner_pkg::*;
#(
    parameter int N_IN   = DEF_N_IN,
    parameter int SETTLE = DEF_SETTLE
) (
    input  logic                  clk,
    input  logic                  rst_n,
    comb_truth_scanner_if.slave   bus
);
    localparam logic [N_IN-1:0] LAST_CODE = {N_IN{1'b1}};

    scan_state_t          state;
    logic [N_IN-1:0]      cba;
    logic                 busy;
    logic                 done;
    logic                 valid;
    logic                 pass;
    logic [2**N_IN-1:0]   tbl;
    logic [N_IN:0]        ones;
    logic                 timer_clr;
    logic                 timer_en;
    logic                 timer_tc;
    logic                 launch;

    assign launch = (state == ST_IDLE) && bus.start && !bus.abort;

    // Timer restarts on every new code and only runs while waiting for the block to settle
    always_comb begin
        timer_clr = launch || (state == ST_SAMPLE);
        timer_en  = (state == ST_WAIT);
    end

    scan_settle_timer #(.SETTLE(SETTLE)) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (timer_clr),
        .en    (timer_en),
        .tc    (timer_tc)
    );

    // Scan sequencer: IDLE -> (WAIT -> SAMPLE) per code -> DONE -> IDLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cba   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            valid <= 1'b0;
            pass  <= 1'b0;
            tbl   <= '0;
            ones  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (launch) begin
                        cba   <= '0;
                        tbl   <= '0;
                        ones  <= '0;
                        valid <= 1'b0;
                        pass  <= 1'b0;
                        busy  <= 1'b1;
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (bus.abort) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else if (timer_tc) begin
                        state <= ST_SAMPLE;
                    end
                end
                ST_SAMPLE: begin
                    if (bus.abort) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else begin
                        tbl[cba] <= bus.y_in;
                        ones     <= ones + (N_IN + 1)'(bus.y_in);
                        if (cba == LAST_CODE) begin
                            done  <= 1'b1;
                            state <= ST_DONE;
                        end else begin
                            cba   <= cba + 1'b1;
                            state <= ST_WAIT;
                        end
                    end
                end
                ST_DONE: begin
                    // tbl is final here; expect_in is only looked at in this cycle
                    busy  <= 1'b0;
                    valid <= 1'b1;
                    pass  <= (tbl == bus.expect_in);
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.cba_out   = cba;
    assign bus.busy      = busy;
    assign bus.done      = done;
    assign bus.valid     = valid;
    assign bus.pass      = pass;
    assign bus.table_out = tbl;
    assign bus.ones_cnt  = ones;
endmodule
